fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb_pkg.sv | 18 +
 rtl/fifo_wr_arb.sv | 93 +++++++++
 2 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared definitions for the UART FIFO write-side blocks: arbiter state
// encodings, the default grant timeout and the timeout counter width.
package fifo_wr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   localparam int TIMEOUT_DEFAULT = 255;
   localparam int TO_CNT_W        = 8;

   function automatic arb_state_t gnt_state(input logic idx);
      return idx ? GNT1 : GNT0;
   endfunction

endpackage

// File: rtl/fifo_wr_arb.sv
// Two-requester, packet-atomic round-robin arbiter in front of a FIFO write
// port, with a grant timeout for requesters that stall mid-packet.
module fifo_wr_arb
   import fifo_wr_arb_pkg::*;
#(
   parameter int DW      = 8,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic          wclk,
   input  logic          rst,
   input  logic          s0_valid,
   input  logic [DW-1:0] s0_data,
   input  logic          s0_last,
   output logic          s0_ready,
   input  logic          s1_valid,
   input  logic [DW-1:0] s1_data,
   input  logic          s1_last,
   output logic          s1_ready,
   input  logic          full,
   output logic          winc,
   output logic [DW-1:0] wdata,
   output logic          busy,
   output logic          owner,
   output logic          to_err,
   output arb_state_t    dbg_state
);

   localparam logic [TO_CNT_W-1:0] TO_LIM = TO_CNT_W'(TIMEOUT);

   // Handshake rule: a byte moves when the state grants requester n,
   // sn_valid=1 and full=0; sn_ready is !full only while n holds the grant.
   arb_state_t          state;
   logic                prio;
   logic [TO_CNT_W-1:0] cnt;
   logic                to_err_q;

   logic gnt0, gnt1, cur_valid, cur_last, hs;

   assign gnt0      = (state == GNT0);
   assign gnt1      = (state == GNT1);
   assign cur_valid = gnt1 ? s1_valid : s0_valid;
   assign cur_last  = gnt1 ? s1_last  : s0_last;
   assign hs        = (gnt0 | gnt1) & cur_valid & ~full;

   assign s0_ready  = gnt0 & ~full;
   assign s1_ready  = gnt1 & ~full;
   assign winc      = hs;
   assign wdata     = gnt0 ? s0_data : (gnt1 ? s1_data : '0);
   assign busy      = gnt0 | gnt1;
   assign owner     = gnt1;
   assign to_err    = to_err_q;
   assign dbg_state = state;

   always_ff @(posedge wclk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         prio     <= 1'b0;
         cnt      <= '0;
         to_err_q <= 1'b0;
      end else begin
         to_err_q <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (s0_valid && s1_valid) state <= gnt_state(prio);
               else if (s0_valid)        state <= GNT0;
               else if (s1_valid)        state <= GNT1;
            end
            GNT0, GNT1: begin
               if (hs) begin
                  cnt <= '0;
                  if (cur_last) begin
                     state <= IDLE;
                     prio  <= ~owner;
                  end
               // Only truly idle cycles count; a full-stalled byte does not.
               end else if (!cur_valid) begin
                  if (cnt + 1'b1 == TO_LIM) begin
                     state    <= IDLE;
                     prio     <= ~owner;
                     to_err_q <= 1'b1;
                     cnt      <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
